// File: rtl/key_entry.sv
// Calculator key sequencer: builds two decimal operands, latches the operation,
// and pulses eqEnable for one cycle on equals. The ALU result is read back for chaining.
module key_entry #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned W          = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         keyValid,
  input  logic [3:0]   keyCode,
  input  logic [W-1:0] result,
  output logic [W-1:0] operator1,
  output logic [W-1:0] operator2,
  output logic [1:0]   operationVal,
  output logic         eqEnable,
  output logic [W-1:0] entryValue
);

  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_OP1  = 2'd0;
  localparam logic [1:0] S_OP2  = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  op1_q, op1_d;
  logic [W-1:0]  op2_q, op2_d;
  logic [1:0]    opv_q, opv_d;
  logic          eq_q, eq_d;

  logic          is_digit, is_op, is_eq, is_clr, room;
  logic [W-1:0]  digit_w;
  logic [1:0]    op_sel;

  function automatic logic [W-1:0] append(input logic [W-1:0] op, input logic [W-1:0] d);
    return (op << 3) + (op << 1) + d;
  endfunction

  always_comb begin
    is_digit = (keyCode < 4'd10);
    is_op    = (keyCode >= 4'd10) && (keyCode <= 4'd12);
    is_eq    = (keyCode == 4'd13);
    is_clr   = (keyCode == 4'd14);
    room     = (cnt_q < CW'(MAX_DIGITS));
    digit_w  = {{(W-4){1'b0}}, keyCode};
    // codes 10/11/12 have low bits 2/3/0; adding 2 maps them to 0/1/2
    op_sel   = keyCode[1:0] + 2'd2;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opv_d   = opv_q;
    eq_d    = 1'b0;

    if (state_q == S_EXEC) begin
      state_d = S_DONE;
    end else if (keyValid) begin
      if (is_clr) begin
        op1_d   = '0;
        op2_d   = '0;
        opv_d   = '0;
        cnt_d   = '0;
        state_d = S_OP1;
      end else begin
        case (state_q)
          S_OP1: begin
            if (is_digit && room) begin
              op1_d = append(op1_q, digit_w);
              cnt_d = cnt_q + CW'(1);
            end else if (is_op) begin
              opv_d   = op_sel;
              op2_d   = '0;
              cnt_d   = '0;
              state_d = S_OP2;
            end
          end
          S_OP2: begin
            if (is_digit && room) begin
              op2_d = append(op2_q, digit_w);
              cnt_d = cnt_q + CW'(1);
            end else if (is_op) begin
              opv_d = op_sel;
            end else if (is_eq) begin
              eq_d    = 1'b1;
              state_d = S_EXEC;
            end
          end
          S_DONE: begin
            if (is_digit) begin
              op1_d   = digit_w;
              op2_d   = '0;
              cnt_d   = CW'(1);
              state_d = S_OP1;
            end else if (is_op) begin
              op1_d   = result;
              opv_d   = op_sel;
              op2_d   = '0;
              cnt_d   = '0;
              state_d = S_OP2;
            end else if (is_eq) begin
              op1_d   = result;
              eq_d    = 1'b1;
              state_d = S_EXEC;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OP1;
      cnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opv_q   <= '0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opv_q   <= opv_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OP1:   entryValue = op1_q;
      S_OP2:   entryValue = op2_q;
      default: entryValue = result;
    endcase
  end

  assign operator1    = op1_q;
  assign operator2    = op2_q;
  assign operationVal = opv_q;
  assign eqEnable     = eq_q;

endmodule

// File: doc/key_entry.md
# key_entry

Calculator front-end sequencer that turns a stream of key codes into the operand/operation/execute signals consumed by the downstream `ALU` stage. It accumulates decimal digits into two 14-bit operands, latches the selected operation and issues a single-cycle `eqEnable` pulse on equals. It reads the ALU's registered `result` back for chaining and repeat-equals, and drives the value to be displayed.

## Interface
- `MAX_DIGITS`, 4: max decimal digits per operand; must satisfy 10^MAX_DIGITS − 1 < 2^W.
- `W`, 14: operand/result width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `keyValid`  in  1  key strobe; one key accepted per cycle it is high.
- `keyCode`  in  4  0–9 digit, 10 add, 11 sub, 12 mult, 13 equals, 14 clear, 15 reserved (ignored).
- `result`  in  W  registered ALU output.
- `operator1`  out  W  first operand to ALU.
- `operator2`  out  W  second operand to ALU.
- `operationVal`  out  2  0 add, 1 sub, 2 mult (ALU encoding).
- `eqEnable`  out  1  execute pulse, exactly one cycle.
- `entryValue`  out  W  value for display.

## Operation
- States (2-bit): S_OP1, S_OP2, S_EXEC, S_DONE. Reset state is S_OP1.
- A private digit counter `cnt` (0..MAX_DIGITS) tracks digits entered for the active operand.
- Digit append rule: `op <= op*10 + d`, with `*10` done as `(op<<3)+(op<<1)` at W bits.
  - Only when `cnt < MAX_DIGITS`; then `cnt++`. Otherwise the digit is dropped.
  - Every accepted digit counts, leading zeros included.
- S_OP1:
  - digit → append to `operator1`.
  - op key → `operationVal <= code−10`, `operator2 <= 0`, `cnt <= 0`, go to S_OP2.
  - equals → ignored.
- S_OP2:
  - digit → append to `operator2`.
  - op key → replace `operationVal`; operand is unchanged.
  - equals → `eqEnable <= 1`, go to S_EXEC.
- S_EXEC:
  - Lasts one cycle; `eqEnable` is high for that cycle only.
  - All keys, including clear, are ignored.
  - Next state is S_DONE.
- S_DONE:
  - digit d → `operator1 <= d`, `operator2 <= 0`, `cnt <= 1`, go to S_OP1.
  - op key → `operator1 <= result`, `operationVal <= code−10`, `operator2 <= 0`, `cnt <= 0`, go to S_OP2.
  - equals → repeat: `operator1 <= result`, keep `operator2` and `operationVal`, `eqEnable <= 1`, go to S_EXEC.
- Clear (any state except S_EXEC) → `operator1`, `operator2`, `operationVal`, `cnt` all 0; go to S_OP1.
- `entryValue` (combinational from state): S_OP1 → `operator1`; S_OP2 → `operator2`; S_EXEC/S_DONE → `result`.
- `keyValid` low, or code 15 → no state or output change.

## Timing
- All outputs are registered except `entryValue`.
- Reset values: `operator1`=0, `operator2`=0, `operationVal`=0, `eqEnable`=0, state S_OP1, `cnt`=0.
- Reset is asynchronous: asserting `rst` low clears all registers immediately, including a live `eqEnable` pulse. Release is synchronous to the next `clk` edge.
- A key is sampled at edge E0; its effect is visible on outputs after E0 (1-cycle latency).
- Equals sampled at E0:
  - `eqEnable` is high E0→E1, with `operator1`/`operator2`/`operationVal` stable.
  - The ALU latches the outputs at E1 and `result` is valid after E1.
  - S_DONE is entered at E1, so the earliest key using `result` is sampled at E2 and is always valid.
- A key presented in the S_EXEC cycle is lost. It is not queued; upstream must re-present it.
- Operands hold their values between keys. No output changes without an accepted key or reset.

## Test plan
- Keys 1,2,add,3,4,equals with `result` stub returning 46:
  - `operator1`=12, `operator2`=34, `operationVal`=0.
  - `eqEnable` high exactly 1 cycle.
  - `entryValue`=46 from S_EXEC onward.
- Keys 1,2,3,4,5 → `operator1`=1234; the fifth digit is dropped; `entryValue`=1234.
- Keys 9,mult,sub,7,equals → `operationVal`=1, `operator1`=9, `operator2`=7, one `eqEnable` pulse. Equals pressed while in S_OP1 produces no pulse.
- Chain and repeat, after test 1 (`result`=46):
  - mult,2,equals → `operator1`=46, `operationVal`=2, `operator2`=2.
  - Set `result`=92, then equals → `operator1`=92, `operator2`=2, second pulse.
- Control keys:
  - A digit presented during the S_EXEC cycle is ignored; state and operands are unchanged.
  - Clear in S_OP2 with `operator2`=56 → all operands 0, `operationVal`=0, S_OP1.
  - Key code 15 has no effect.
- Reset:
  - Drive `rst` low mid-cycle while `eqEnable`=1 → all outputs 0 before the next clock edge.
  - After release, keys 5,add,5,equals produce a normal pulse.
